// File: rtl/jtsdram_multichk.sv
// jtsdram_multichk: SDRAM bank checker for the JTSDRAM test core.
// Each of BANKS channels walks a pseudo-random sequence of even addresses.
// A read-only bank reads each address and compares the word against a
// pattern derived from the address. A read/write bank first writes the
// LFSR upper half, then reads the same address back and compares.
// Ports:
//   clk, rst_n (sync, active-low), enable, clr_bad  - control
//   ba_addr/ba_rd/ba_wr/ba_din/ba_din_m             - requests to controller
//   ba_ack/ba_rdy/data_read                         - controller responses
//   bad/tmo (sticky), ok (pulse)                    - per-bank status

module jtsdram_multichk_bank #(
    parameter int          AW   = 22,
    parameter bit          RW   = 1'b0,
    parameter logic [31:0] SEED = 32'h1,
    parameter logic [7:0]  TMO  = 8'd200
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          clr_bad,
    input  logic          ack,
    input  logic          rdy,
    input  logic [31:0]   data_read,
    output logic [AW-1:0] addr,
    output logic          rd,
    output logic          wr,
    output logic [15:0]   din,
    output logic          bad,
    output logic          tmo,
    output logic          ok
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, CHECK, NEXT} state_t;

    state_t      state, state_nx;
    logic [31:0] lfsr;
    logic        wphase;    // current REQ/WAIT is the write half of a pair
    logic [7:0]  cnt;
    logic [31:0] dat;
    logic        tmo_hit;
    logic        match;

    function automatic logic [15:0] pat(input logic [AW-1:0] x);
        logic [AW-1:0] hi;
        hi = x >> 16;
        return x[15:0] ^ hi[15:0];
    endfunction

    // Timeout fires on the WAIT cycle that would bring the count to TMO;
    // a rdy in that same cycle still wins.
    assign tmo_hit = (state == WAIT) && !rdy && (cnt == TMO - 8'd1);

    always_comb begin
        if (RW) match = (dat[15:0] == din);
        else    match = (dat == {pat(addr | AW'(1)), pat(addr)});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (enable) state_nx = REQ;
            REQ:   if (ack) state_nx = WAIT;
            // A finished write always continues to its read-back, even
            // when enable has dropped.
            WAIT:  if (rdy) state_nx = wphase ? REQ : CHECK;
                   else if (tmo_hit) state_nx = NEXT;
            CHECK: state_nx = NEXT;
            NEXT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rd = (state == REQ) && !wphase;
        wr = (state == REQ) && wphase;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr   <= SEED;
            addr   <= '0;
            din    <= '0;
            wphase <= 1'b0;
            cnt    <= '0;
            dat    <= '0;
            bad    <= 1'b0;
            tmo    <= 1'b0;
            ok     <= 1'b0;
        end else begin
            ok <= 1'b0;
            // Flags raised below in the same cycle override the clear.
            if (clr_bad) begin
                bad <= 1'b0;
                tmo <= 1'b0;
            end
            case (state)
                IDLE: if (enable) begin
                    addr   <= {lfsr[AW-1:1], 1'b0};
                    din    <= RW ? lfsr[31:16] : 16'h0;
                    wphase <= RW;
                end
                REQ:  cnt <= '0;
                WAIT: begin
                    if (rdy) begin
                        dat    <= data_read;
                        wphase <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                    if (tmo_hit) begin
                        tmo <= 1'b1;
                        bad <= 1'b1;
                    end
                end
                CHECK: if (match) ok <= 1'b1;
                       else       bad <= 1'b1;
                NEXT: lfsr <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
                default: ;
            endcase
        end
    end
endmodule

module jtsdram_multichk #(
    parameter int          BANKS   = 4,
    parameter int          AW      = 22,
    parameter logic [3:0]  RW_MASK = 4'b0001,
    parameter logic [31:0] SEED    = 32'h1234_5678,
    parameter logic [7:0]  TMO     = 8'd200
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  clr_bad,
    output logic [BANKS*AW-1:0]   ba_addr,
    output logic [BANKS-1:0]      ba_rd,
    output logic [BANKS-1:0]      ba_wr,
    output logic [16*BANKS-1:0]   ba_din,
    output logic [2*BANKS-1:0]    ba_din_m,
    input  logic [BANKS-1:0]      ba_ack,
    input  logic [BANKS-1:0]      ba_rdy,
    input  logic [31:0]           data_read,
    output logic [BANKS-1:0]      bad,
    output logic [BANKS-1:0]      tmo,
    output logic [BANKS-1:0]      ok
);
    assign ba_din_m = '0;

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        // An all-zero seed would lock the LFSR, so it is replaced by 1.
        localparam logic [31:0] S0 = SEED ^ 32'(b);
        localparam logic [31:0] S  = (S0 == 32'd0) ? 32'd1 : S0;

        jtsdram_multichk_bank #(
            .AW(AW), .RW(RW_MASK[b]), .SEED(S), .TMO(TMO)
        ) u_bank (
            .clk       (clk),
            .rst_n     (rst_n),
            .enable    (enable),
            .clr_bad   (clr_bad),
            .ack       (ba_ack[b]),
            .rdy       (ba_rdy[b]),
            .data_read (data_read),
            .addr      (ba_addr[b*AW +: AW]),
            .rd        (ba_rd[b]),
            .wr        (ba_wr[b]),
            .din       (ba_din[b*16 +: 16]),
            .bad       (bad[b]),
            .tmo       (tmo[b]),
            .ok        (ok[b])
        );
    end
endmodule

// File: tb/tb_jtsdram_multichk.sv
// Bench for jtsdram_multichk: an SDRAM controller model with random
// latencies, a reference LFSR/address model per bank, fault injection
// (bit flips, lost writes, missing rdy) and flag timing checks.
module tb_jtsdram_multichk;
    localparam int          NB   = 4;
    localparam int          AW   = 22;
    localparam logic [3:0]  RWM  = 4'b0001;
    localparam logic [31:0] SEED = 32'h1234_5678;

    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, clr_bad = 1'b0;
    logic [NB*AW-1:0] ba_addr;
    logic [NB-1:0]    ba_rd, ba_wr, ba_ack, ba_rdy, bad, tmo, ok;
    logic [16*NB-1:0] ba_din;
    logic [2*NB-1:0]  ba_din_m;
    logic [31:0]      data_read;

    jtsdram_multichk #(.BANKS(NB), .AW(AW), .RW_MASK(RWM), .SEED(SEED), .TMO(8'd20)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr_bad(clr_bad),
        .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_wr(ba_wr), .ba_din(ba_din),
        .ba_din_m(ba_din_m), .ba_ack(ba_ack), .ba_rdy(ba_rdy),
        .data_read(data_read), .bad(bad), .tmo(tmo), .ok(ok));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_adv(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction
    function automatic logic [31:0] seed_of(input int b);
        logic [31:0] s;
        s = SEED ^ 32'(b);
        return (s == 0) ? 32'd1 : s;
    endfunction
    function automatic logic [AW-1:0] model_addr(input logic [31:0] l);
        return {l[AW-1:1], 1'b0};
    endfunction
    function automatic logic [15:0] pat(input logic [AW-1:0] x);
        logic [AW-1:0] h;
        h = x >> 16;
        return x[15:0] ^ h[15:0];
    endfunction

    // controller model / scoreboard state
    int busy[NB], lat[NB], req_b[NB], good[NB], okcnt[NB], ev_cyc[NB];
    int cyc = 0, req_cnt = 0;
    int ack_min = 1, ack_max = 4, rdy_min = 1, rdy_max = 12;
    logic [31:0]   lm[NB];
    logic [15:0]   lm_w[NB], first_d[NB];
    logic [AW-1:0] cur_a[NB], first_a[NB];
    logic          cur_wr[NB], pend_rd[NB], dropw[NB], hang[NB];
    logic [31:0]   flip[NB];
    logic [15:0]   mem[logic [AW-1:0]];

    function automatic bit fault_pending(input int b);
        return (flip[b] != 0) || dropw[b] || hang[b];
    endfunction

    initial begin
        logic [AW-1:0] a;
        logic [31:0]   d, e;
        bit            g, slot;
        ba_ack = '0; ba_rdy = '0; data_read = '0;
        for (int b = 0; b < NB; b++) begin
            flip[b] = 0; dropw[b] = 0; hang[b] = 0; ev_cyc[b] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            ba_ack = '0; ba_rdy = '0;
            if (!rst_n) begin
                for (int b = 0; b < NB; b++) begin
                    busy[b] = 0; lm[b] = seed_of(b); pend_rd[b] = 0;
                    good[b] = 0; okcnt[b] = 0; req_b[b] = 0;
                end
            end else begin
                slot = 1;
                for (int b = 0; b < NB; b++) begin
                    if (ok[b]) okcnt[b]++;
                    case (busy[b])
                        0: if (ba_rd[b] || ba_wr[b]) begin
                            a = ba_addr[b*AW +: AW];
                            if (req_b[b] == 0) begin
                                first_a[b] = a; first_d[b] = ba_din[b*16 +: 16];
                            end
                            req_b[b]++; req_cnt++;
                            chk("req_kind", {ba_rd[b], ba_wr[b]},
                                (RWM[b] && !pend_rd[b]) ? 2'b01 : 2'b10);
                            chk("req_addr", a, model_addr(lm[b]));
                            if (ba_wr[b]) begin
                                chk("wr_din", ba_din[b*16 +: 16], lm[b][31:16]);
                                chk("wr_mask", ba_din_m[b*2 +: 2], 0);
                                lm_w[b] = lm[b][31:16];
                                pend_rd[b] = 1;
                            end else begin
                                pend_rd[b] = 0;
                                lm[b] = lfsr_adv(lm[b]);
                            end
                            cur_a[b] = a; cur_wr[b] = ba_wr[b]; busy[b] = 1;
                            lat[b] = int'($urandom_range(ack_max, ack_min)) - 1;
                        end
                        1: begin
                            chk("req_held", ba_rd[b] | ba_wr[b], 1);
                            chk("addr_hold", ba_addr[b*AW +: AW], cur_a[b]);
                            if (lat[b] > 0) lat[b]--;
                            else begin
                                ba_ack[b] = 1;
                                if (hang[b]) begin
                                    hang[b] = 0; ev_cyc[b] = cyc; busy[b] = 0;
                                end else begin
                                    busy[b] = 2;
                                    lat[b] = int'($urandom_range(rdy_max, rdy_min)) - 1;
                                end
                            end
                        end
                        default: begin
                            chk("req_drop", ba_rd[b] | ba_wr[b], 0);
                            chk("addr_hold", ba_addr[b*AW +: AW], cur_a[b]);
                            if (lat[b] > 0) lat[b]--;
                            else if (slot) begin
                                slot = 0; ba_rdy[b] = 1; busy[b] = 0;
                                if (cur_wr[b]) begin
                                    // a lost write leaves garbage in the cell
                                    mem[cur_a[b]] = dropw[b] ? ~lm_w[b] : lm_w[b];
                                    dropw[b] = 0;
                                    d = $urandom;
                                end else begin
                                    if (RWM[b])
                                        e = {16'($urandom), mem.exists(cur_a[b]) ? mem[cur_a[b]] : 16'h0};
                                    else
                                        e = {pat({cur_a[b][AW-1:1], 1'b1}), pat(cur_a[b])};
                                    d = e ^ flip[b];
                                    flip[b] = 0;
                                    g = RWM[b] ? (d[15:0] == lm_w[b])
                                               : (d == {pat({cur_a[b][AW-1:1], 1'b1}), pat(cur_a[b])});
                                    if (g) good[b]++;
                                    else   ev_cyc[b] = cyc;
                                end
                                data_read = d;
                            end
                        end
                    endcase
                end
            end
        end
    end

    task automatic step();
        @(negedge clk); #1;
    endtask
    task automatic step_n(input int n);
        repeat (n) step();
    endtask
    task automatic pulse_clr();
        clr_bad = 1; step(); clr_bad = 0;
    endtask
    task automatic wait_fault(input string nm, input int b);
        for (int k = 0; k < 3000 && fault_pending(b); k++) step();
        chk(nm, fault_pending(b), 0);
    endtask
    task automatic drain(input string nm);
        int idle = 0;
        for (int k = 0; k < 3000 && idle < 10; k++) begin
            step();
            if (busy[0] == 0 && busy[1] == 0 && busy[2] == 0 && busy[3] == 0
                && (ba_rd | ba_wr) == 0) idle++;
            else idle = 0;
        end
        chk(nm, idle >= 10, 1);
    endtask
    task automatic check_counts(input string nm);
        for (int b = 0; b < NB; b++) chk(nm, okcnt[b], good[b]);
    endtask

    typedef struct {
        int         bank;
        int         kind;     // 0 flip read data, 1 lose write, 2 never rdy
        logic [31:0] mask;
        logic [3:0] xbad;
        logic [3:0] xtmo;
    } vec_t;

    initial begin
        vec_t tv[7];
        int c, rc, k;
        logic [AW-1:0] hung;
        bit done;

        tv[0] = '{2, 0, 32'h0000_0020, 4'b0100, 4'b0000};
        tv[1] = '{0, 1, 32'h0,         4'b0001, 4'b0000};
        tv[2] = '{1, 2, 32'h0,         4'b0010, 4'b0010};
        tv[3] = '{3, 0, 32'h8000_0000, 4'b1000, 4'b0000};
        tv[4] = '{0, 0, 32'h0000_0008, 4'b0001, 4'b0000};
        tv[5] = '{0, 0, 32'h0010_0000, 4'b0000, 4'b0000}; // upper half unused on r/w bank
        tv[6] = '{1, 0, 32'h0001_0000, 4'b0010, 4'b0000};

        // reset state
        step_n(3);
        chk("rst_rd", ba_rd, 0);
        chk("rst_wr", ba_wr, 0);
        chk("rst_addr", ba_addr, 0);
        chk("rst_din", ba_din, 0);
        chk("rst_din_m", ba_din_m, 0);
        chk("rst_bad", bad, 0);
        chk("rst_tmo", tmo, 0);
        chk("rst_ok", ok, 0);

        // randomized run
        rst_n = 1; enable = 1;
        done = 0;
        for (k = 0; k < 40000 && !done; k++) begin
            step();
            done = (good[0] >= 250) && (good[1] >= 250) && (good[2] >= 250) && (good[3] >= 250);
        end
        chk("rand_run", done, 1);
        enable = 0;
        drain("rand_drain");
        check_counts("rand_ok_count");
        chk("rand_bad", bad, 0);
        chk("rand_tmo", tmo, 0);

        // fault table at fixed latencies
        ack_min = 3; ack_max = 3; rdy_min = 10; rdy_max = 10;
        enable = 1;
        for (int i = 0; i < 7; i++) begin
            pulse_clr();
            chk("tv_clr", {tmo, bad}, 0);
            case (tv[i].kind)
                0: flip[tv[i].bank] = tv[i].mask;
                1: dropw[tv[i].bank] = 1;
                default: hang[tv[i].bank] = 1;
            endcase
            wait_fault("tv_fault", tv[i].bank);
            step_n(60);
            chk("tv_bad", bad, tv[i].xbad);
            chk("tv_tmo", tmo, tv[i].xtmo);
        end

        // bad latency: two cycles after the corrupted rdy
        pulse_clr();
        flip[2] = 32'h20;
        wait_fault("lat_fault", 2);
        c = ev_cyc[2];
        step();
        chk("lat_cyc", cyc, c + 1);
        chk("lat_early", bad, 0);
        step();
        chk("lat_bad", bad, 4'b0100);

        // clear coincident with a new error: error wins, others clear
        pulse_clr();
        flip[3] = 32'h1;
        wait_fault("prec_fault3", 3);
        step_n(5);
        chk("prec_pre", bad, 4'b1000);
        flip[2] = 32'h1;
        wait_fault("prec_fault2", 2);
        c = ev_cyc[2];
        step();
        clr_bad = 1;
        step();
        clr_bad = 0;
        chk("prec_bad", bad, 4'b0100);

        // timeout timing on bank 1
        pulse_clr();
        hang[1] = 1;
        wait_fault("tmo_fault", 1);
        c = ev_cyc[1];
        hung = cur_a[1];
        rc = req_b[1];
        step_n(20);
        chk("tmo_early", tmo, 0);
        step();
        chk("tmo_set", tmo, 4'b0010);
        chk("tmo_bad", bad, 4'b0010);
        for (k = 0; k < 200 && req_b[1] == rc; k++) step();
        chk("tmo_next_req", req_b[1], rc + 1);
        chk("tmo_new_addr", cur_a[1] == hung, 0);

        // lone clear pulse
        pulse_clr();
        chk("clr_bad", bad, 0);
        chk("clr_tmo", tmo, 0);

        // enable drop while the r/w bank waits for its write
        for (k = 0; k < 3000 && !(busy[0] == 2 && cur_wr[0]); k++) step();
        chk("en_wait_wr", busy[0] == 2 && cur_wr[0], 1);
        enable = 0;
        drain("en_drain");
        chk("en_readback", pend_rd[0], 0);
        rc = req_cnt;
        step_n(100);
        chk("en_no_req", req_cnt, rc);
        chk("en_idle", ba_rd | ba_wr, 0);
        check_counts("en_ok_count");
        chk("en_bad", bad, 0);

        // reset in the middle of a request
        enable = 1;
        for (k = 0; k < 3000 && busy[1] != 1; k++) step();
        chk("rst_in_req", busy[1], 1);
        rst_n = 0;
        step();
        chk("rst_mid_rd", ba_rd, 0);
        chk("rst_mid_wr", ba_wr, 0);
        step();
        rst_n = 1;
        for (k = 0; k < 200 && (req_b[0] == 0 || req_b[2] == 0); k++) step();
        chk("seed_a0", first_a[0], 22'h345678);
        chk("seed_d0", first_d[0], 16'h1234);
        chk("seed_a2", first_a[2], 22'h34567A);
        step_n(300);
        enable = 0;
        drain("rst_drain");
        check_counts("rst_ok_count");
        chk("rst_end_bad", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
